// File: rtl/c1541_pkg.sv
// Shared types and 1541 disk-zone geometry for the track buffer controller.
package c1541_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_XFER = 3'd2,
    RD_REQ  = 3'd3,
    RD_XFER = 3'd4
  } state_e;

  // First track of zones 2..4; zone 1 starts at track 1.
  localparam logic [5:0]  ZONE2_TRACK = 6'd18;
  localparam logic [5:0]  ZONE3_TRACK = 6'd25;
  localparam logic [5:0]  ZONE4_TRACK = 6'd31;

  localparam logic [15:0] ZONE1_START = 16'd0;
  localparam logic [15:0] ZONE2_START = 16'd357;
  localparam logic [15:0] ZONE3_START = 16'd490;
  localparam logic [15:0] ZONE4_START = 16'd598;

  localparam logic [4:0]  ZONE1_SECS  = 5'd21;
  localparam logic [4:0]  ZONE2_SECS  = 5'd19;
  localparam logic [4:0]  ZONE3_SECS  = 5'd18;
  localparam logic [4:0]  ZONE4_SECS  = 5'd17;

  // The head position register can read 0 before the first step; it means track 1.
  function automatic logic [5:0] norm_track(input logic [5:0] trk);
    return (trk == 6'd0) ? 6'd1 : trk;
  endfunction

endpackage

// File: rtl/c1541_track_geom.sv
// Maps a (normalised) track number to its first image sector and sector count minus one.
module c1541_track_geom
  import c1541_pkg::*;
(
  input  logic [5:0]  track,
  output logic [15:0] start_sector,
  output logic [4:0]  blk_cnt
);

  logic [15:0] trk_s;

  assign trk_s = {10'd0, track};

  // Zone lookup: start = zone base + tracks into zone * sectors per track.
  always_comb begin
    start_sector = ZONE1_START;
    blk_cnt      = ZONE1_SECS - 5'd1;
    if (track < ZONE2_TRACK) begin
      start_sector = ZONE1_START + (trk_s - 16'd1) * {11'd0, ZONE1_SECS};
      blk_cnt      = ZONE1_SECS - 5'd1;
    end else if (track < ZONE3_TRACK) begin
      start_sector = ZONE2_START + (trk_s - {10'd0, ZONE2_TRACK}) * {11'd0, ZONE2_SECS};
      blk_cnt      = ZONE2_SECS - 5'd1;
    end else if (track < ZONE4_TRACK) begin
      start_sector = ZONE3_START + (trk_s - {10'd0, ZONE3_TRACK}) * {11'd0, ZONE3_SECS};
      blk_cnt      = ZONE3_SECS - 5'd1;
    end else begin
      start_sector = ZONE4_START + (trk_s - {10'd0, ZONE4_TRACK}) * {11'd0, ZONE4_SECS};
      blk_cnt      = ZONE4_SECS - 5'd1;
    end
  end

endmodule

// File: rtl/c1541_track_ctrl.sv
// Track buffer sequencer: after the head settles on a new track, flushes the dirty
// buffer to the SD image and loads the new track, holding busy while it does so.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd20000,
  parameter logic [31:0] IMG_BASE      = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [5:0]  track,
  input  logic        buf_we,
  output logic        busy,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_blk_cnt,
  input  logic        sd_ack,
  output logic [5:0]  cur_track
);

  state_e      state_r, state_n;
  logic [15:0] count_r, count_n;
  logic [5:0]  prev_t_r, prev_t_n;
  logic        valid_r, valid_n;
  logic        dirty_r, dirty_n;
  logic        mount_pend_r, mount_pend_n;
  logic        busy_r, busy_n;
  logic        sd_rd_r, sd_rd_n;
  logic        sd_wr_r, sd_wr_n;
  logic [31:0] sd_lba_r, sd_lba_n;
  logic [4:0]  sd_blk_r, sd_blk_n;
  logic [5:0]  cur_track_r, cur_track_n;

  logic [5:0]  t_s;
  logic [15:0] new_start_s, cur_start_s;
  logic [4:0]  new_blk_s, cur_blk_s;

  assign t_s = norm_track(track);

  c1541_track_geom u_geom_new (.track(t_s),         .start_sector(new_start_s), .blk_cnt(new_blk_s));
  c1541_track_geom u_geom_cur (.track(cur_track_r), .start_sector(cur_start_s), .blk_cnt(cur_blk_s));

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_n      = state_r;
    count_n      = count_r;
    prev_t_n     = t_s;
    valid_n      = valid_r;
    dirty_n      = dirty_r;
    mount_pend_n = mount_pend_r;
    sd_rd_n      = sd_rd_r;
    sd_wr_n      = sd_wr_r;
    sd_lba_n     = sd_lba_r;
    sd_blk_n     = sd_blk_r;
    cur_track_n  = cur_track_r;

    case (state_r)
      IDLE: begin
        if (buf_we && !img_readonly && valid_r) begin
          dirty_n = 1'b1;
        end else begin
          dirty_n = dirty_r;
        end
        if (img_mounted) begin
          count_n = 16'd0;
        end else if (t_s != prev_t_r) begin
          count_n = 16'd0;
        end else if ((t_s != cur_track_r) || !valid_r) begin
          if (count_r == SETTLE_CYCLES - 16'd1) begin
            count_n = 16'd0;
            if (dirty_r && valid_r) begin
              state_n  = WR_REQ;
              sd_wr_n  = 1'b1;
              sd_lba_n = IMG_BASE + {16'd0, cur_start_s};
              sd_blk_n = cur_blk_s;
            end else begin
              state_n     = RD_REQ;
              sd_rd_n     = 1'b1;
              sd_lba_n    = IMG_BASE + {16'd0, new_start_s};
              sd_blk_n    = new_blk_s;
              cur_track_n = t_s;
            end
          end else begin
            count_n = count_r + 16'd1;
          end
        end else begin
          count_n = 16'd0;
        end
      end
      WR_REQ: begin
        if (sd_ack) begin
          sd_wr_n = 1'b0;
          state_n = WR_XFER;
        end else begin
          state_n = WR_REQ;
        end
      end
      WR_XFER: begin
        if (!sd_ack) begin
          dirty_n     = 1'b0;
          state_n     = RD_REQ;
          sd_rd_n     = 1'b1;
          sd_lba_n    = IMG_BASE + {16'd0, new_start_s};
          sd_blk_n    = new_blk_s;
          cur_track_n = t_s;
        end else begin
          state_n = WR_XFER;
        end
      end
      RD_REQ: begin
        if (sd_ack) begin
          sd_rd_n = 1'b0;
          state_n = RD_XFER;
        end else begin
          state_n = RD_REQ;
        end
      end
      RD_XFER: begin
        // A mount seen mid-transfer leaves the freshly loaded data invalid.
        if (!sd_ack) begin
          valid_n      = !mount_pend_r;
          mount_pend_n = 1'b0;
          count_n      = 16'd0;
          state_n      = IDLE;
        end else begin
          state_n = RD_XFER;
        end
      end
      default: begin
        state_n = IDLE;
        sd_rd_n = 1'b0;
        sd_wr_n = 1'b0;
      end
    endcase

    valid_n      = img_mounted ? 1'b0 : valid_n;
    dirty_n      = img_mounted ? 1'b0 : dirty_n;
    mount_pend_n = img_mounted ? (state_n != IDLE) : mount_pend_n;
    busy_n       = (state_n != IDLE) || !valid_n;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      count_r      <= 16'd0;
      prev_t_r     <= 6'd1;
      valid_r      <= 1'b0;
      dirty_r      <= 1'b0;
      mount_pend_r <= 1'b0;
      busy_r       <= 1'b1;
      sd_rd_r      <= 1'b0;
      sd_wr_r      <= 1'b0;
      sd_lba_r     <= 32'd0;
      sd_blk_r     <= 5'd0;
      cur_track_r  <= 6'd0;
    end else begin
      state_r      <= state_n;
      count_r      <= count_n;
      prev_t_r     <= prev_t_n;
      valid_r      <= valid_n;
      dirty_r      <= dirty_n;
      mount_pend_r <= mount_pend_n;
      busy_r       <= busy_n;
      sd_rd_r      <= sd_rd_n;
      sd_wr_r      <= sd_wr_n;
      sd_lba_r     <= sd_lba_n;
      sd_blk_r     <= sd_blk_n;
      cur_track_r  <= cur_track_n;
    end
  end

  assign busy       = busy_r;
  assign sd_rd      = sd_rd_r;
  assign sd_wr      = sd_wr_r;
  assign sd_lba     = sd_lba_r;
  assign sd_blk_cnt = sd_blk_r;
  assign cur_track  = cur_track_r;

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Self-checking bench for c1541_track_ctrl: a zone table of track loads plus
// hand-written write-back, read-only, stepping, mount and reset sequences.
module tb_c1541_track_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        img_mounted;
  logic        img_readonly;
  logic [5:0]  track;
  logic        buf_we;
  logic        busy;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_lba;
  logic [4:0]  sd_blk_cnt;
  logic        sd_ack;
  logic [5:0]  cur_track;

  always #5 clk = ~clk;

  c1541_track_ctrl #(.SETTLE_CYCLES(16'd8), .IMG_BASE(32'd0)) dut (
    .clk(clk), .reset_n(reset_n), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .track(track), .buf_we(buf_we), .busy(busy), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_ack(sd_ack), .cur_track(cur_track)
  );

  typedef struct {
    logic        wr;
    logic [31:0] lba;
    logic [4:0]  blk;
  } req_t;

  typedef struct {
    logic [5:0]  trk;
    logic [31:0] lba;
    logic [4:0]  blk;
    logic [5:0]  cur;
  } vec_t;

  req_t exp_q[$];
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] lba, input logic [4:0] blk);
    req_t r;
    r.wr  = wr;
    r.lba = lba;
    r.blk = blk;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for a request and compare it against the scoreboard head.
  task automatic wait_req(output int lat);
    req_t e;
    lat = 0;
    while (!(sd_rd || sd_wr) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!(sd_rd || sd_wr)) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: no request after %0d cycles, expected one", lat);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=%0d, expected none", sd_rd, sd_wr, sd_lba);
    end else begin
      e = exp_q.pop_front();
      check("req_wr",  {31'd0, sd_wr}, {31'd0, e.wr});
      check("req_rd",  {31'd0, sd_rd}, {31'd0, !e.wr});
      check("req_lba", sd_lba, e.lba);
      check("req_blk", {27'd0, sd_blk_cnt}, {27'd0, e.blk});
    end
  endtask

  // Hold sd_ack for len cycles, optionally pulsing img_mounted inside the transfer.
  task automatic ack_xfer(input int len, input logic mount);
    sd_ack = 1'b1;
    @(negedge clk);
    check("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
    if (mount) img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    repeat (len - 2) @(negedge clk);
    check("busy_in_xfer", {31'd0, busy}, 32'd1);
    sd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_we();
    buf_we = 1'b1;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nreq;

    vecs[0] = '{trk: 6'd18, lba: 32'd357, blk: 5'd18, cur: 6'd18};
    vecs[1] = '{trk: 6'd25, lba: 32'd490, blk: 5'd17, cur: 6'd25};
    vecs[2] = '{trk: 6'd35, lba: 32'd666, blk: 5'd16, cur: 6'd35};
    vecs[3] = '{trk: 6'd17, lba: 32'd336, blk: 5'd20, cur: 6'd17};
    vecs[4] = '{trk: 6'd24, lba: 32'd471, blk: 5'd18, cur: 6'd24};
    vecs[5] = '{trk: 6'd30, lba: 32'd580, blk: 5'd17, cur: 6'd30};
    vecs[6] = '{trk: 6'd31, lba: 32'd598, blk: 5'd16, cur: 6'd31};
    vecs[7] = '{trk: 6'd40, lba: 32'd751, blk: 5'd16, cur: 6'd40};
    vecs[8] = '{trk: 6'd0,  lba: 32'd0,   blk: 5'd20, cur: 6'd1};

    reset_n = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    track = 6'd1; buf_we = 1'b0; sd_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd1);
    check("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_lba",   sd_lba, 32'd0);
    check("rst_blk",   {27'd0, sd_blk_cnt}, 32'd0);
    check("rst_cur",   {26'd0, cur_track}, 32'd0);

    // Initial load of track 1 after the settle time.
    reset_n = 1'b1;
    push(1'b0, 32'd0, 5'd20);
    wait_req(lat);
    check("t1_latency", lat, 32'd8);
    ack_xfer(4, 1'b0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_cur", {26'd0, cur_track}, 32'd1);

    // Zone table: each track change reloads a clean buffer.
    for (int i = 0; i < 9; i++) begin
      track = vecs[i].trk;
      push(1'b0, vecs[i].lba, vecs[i].blk);
      wait_req(lat);
      ack_xfer(4, 1'b0);
      check("tbl_busy", {31'd0, busy}, 32'd0);
      check("tbl_cur", {26'd0, cur_track}, {26'd0, vecs[i].cur});
    end
    track = 6'd1;

    // Dirty buffer is written back before the new track loads.
    @(negedge clk);
    pulse_we();
    track = 6'd2;
    push(1'b1, 32'd0, 5'd20);
    push(1'b0, 32'd21, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b0);
    wait_req(lat);
    ack_xfer(4, 1'b0);
    check("wb_busy", {31'd0, busy}, 32'd0);
    track = 6'd3;
    push(1'b0, 32'd42, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b0);

    // Read-only image: writes never dirty the buffer.
    img_readonly = 1'b1;
    pulse_we();
    track = 6'd4;
    push(1'b0, 32'd63, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b0);
    img_readonly = 1'b0;

    // Rapid stepping yields a single load of the final track.
    track = 6'd1;
    push(1'b0, 32'd0, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b0);
    nreq = 0;
    for (int s = 2; s <= 4; s++) begin
      track = 6'(s);
      if (s < 4) begin
        repeat (3) begin
          @(negedge clk);
          if (sd_rd || sd_wr) nreq++;
        end
      end
    end
    check("step_early_req", nreq, 32'd0);
    push(1'b0, 32'd63, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b0);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_rd || sd_wr) nreq++;
    end
    check("step_extra_req", nreq, 32'd0);

    // Mount during a load: data stays invalid and the same track reloads.
    track = 6'd5;
    push(1'b0, 32'd84, 5'd20);
    wait_req(lat);
    ack_xfer(4, 1'b1);
    check("mnt_busy", {31'd0, busy}, 32'd1);
    push(1'b0, 32'd84, 5'd20);
    wait_req(lat);
    check("mnt_latency", lat, 32'd8);
    ack_xfer(4, 1'b0);
    check("mnt_done_busy", {31'd0, busy}, 32'd0);
    check("mnt_cur", {26'd0, cur_track}, 32'd5);

    // Asynchronous reset while a write-back is requested.
    pulse_we();
    track = 6'd6;
    push(1'b1, 32'd84, 5'd20);
    wait_req(lat);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd1);
    check("arst_lba",   sd_lba, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(1'b0, 32'd105, 5'd20);
    wait_req(lat);
    check("arst_settled", {31'd0, (lat >= 8)}, 32'd1);
    ack_xfer(4, 1'b0);
    check("arst_cur", {26'd0, cur_track}, 32'd6);
    check("arst_busy_done", {31'd0, busy}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
